// File: rtl/lut_config_loader.sv
// Serial-to-parallel loader for the soft-coded fracturable LUT. It assembles an
// MSB-first framed bitstream and commits the finished word with a one-cycle config_en.
module lut_config_loader #(
    parameter int INPUTS    = 4,
    parameter int MEM_SIZE  = 2**INPUTS,
    parameter int CFG_WIDTH = 2*MEM_SIZE + 1,
    parameter int CNT_W     = $clog2(CFG_WIDTH + 1)
) (
    input  logic                 config_clk,
    input  logic                 config_rst,
    input  logic                 load_start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [CFG_WIDTH-1:0] config_out,
    output logic                 config_en,
    output logic                 busy,
    output logic                 loaded,
    output logic [CNT_W-1:0]     bit_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Count value just before the final bit of a frame is accepted.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_WIDTH - 1);

    state_t               state;
    logic [CFG_WIDTH-1:0] shift_reg;
    logic [CFG_WIDTH-1:0] next_word;
    logic                 accept;

    assign accept    = bit_valid && bit_ready;
    assign next_word = {shift_reg[CFG_WIDTH-2:0], bit_in};

    // Handshake and strobe outputs are registered alongside the state so that
    // no input reaches an output combinationally.
    always_ff @(posedge config_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create ordering races.
        if (config_rst) begin
            // NOTE: the shift register is an ordinary register bank, not a RAM,
            // so clearing it on reset is cheap and keeps restarts deterministic.
            state      <= IDLE;
            shift_reg  <= '0;
            config_out <= '0;
            bit_count  <= '0;
            config_en  <= 1'b0;
            bit_ready  <= 1'b0;
            busy       <= 1'b0;
            loaded     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_count <= '0;
                        loaded    <= 1'b0;
                        bit_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (load_start) begin
                        // Restart discards the partial frame and the bit offered now.
                        shift_reg <= '0;
                        bit_count <= '0;
                    end else if (accept) begin
                        shift_reg <= next_word;
                        bit_count <= bit_count + CNT_W'(1);
                        if (bit_count == LAST_IDX) begin
                            config_out <= next_word;
                            state      <= COMMIT;
                            bit_ready  <= 1'b0;
                            config_en  <= 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    // load_start is ignored here; the commit always completes.
                    state     <= IDLE;
                    config_en <= 1'b0;
                    busy      <= 1'b0;
                    loaded    <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    config_en <= 1'b0;
                    bit_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: stimulus pushes expected commits into a
// scoreboard queue, and a negedge monitor pops and compares each config_en pulse.
module tb_lut_config_loader;

    localparam int CFG_WIDTH = 33;
    localparam int CNT_W     = 6;

    logic                 config_clk = 1'b0;
    logic                 config_rst = 1'b1;
    logic                 load_start = 1'b0;
    logic                 bit_in     = 1'b0;
    logic                 bit_valid  = 1'b0;
    logic                 bit_ready;
    logic [CFG_WIDTH-1:0] config_out;
    logic                 config_en;
    logic                 busy;
    logic                 loaded;
    logic [CNT_W-1:0]     bit_count;

    typedef struct {
        logic [CFG_WIDTH-1:0] word;
        int                   cycle;
    } exp_t;

    exp_t q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    lut_config_loader dut (
        .config_clk (config_clk),
        .config_rst (config_rst),
        .load_start (load_start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .config_out (config_out),
        .config_en  (config_en),
        .busy       (busy),
        .loaded     (loaded),
        .bit_count  (bit_count)
    );

    always #5 config_clk = ~config_clk;
    always @(posedge config_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every commit strobe must match the oldest pending expectation.
    always @(negedge config_clk) begin
        if (config_en === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_commit", 64'(config_out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("commit_word", 64'(config_out), 64'(e.word));
                check("commit_cycle", 64'(cyc), 64'(e.cycle));
            end
        end
    end

    task automatic tick();
        @(posedge config_clk);
        #1;
    endtask

    task automatic push_exp(input logic [CFG_WIDTH-1:0] word, input int cycle);
        exp_t e;
        e.word  = word;
        e.cycle = cycle;
        q.push_back(e);
    endtask

    // Issues load_start in the current cycle; returns that cycle number.
    task automatic start_frame(output int start_cyc);
        load_start = 1'b1;
        start_cyc  = cyc;
        tick();
        load_start = 1'b0;
    endtask

    // Shifts the first nbits of word MSB-first; with throttle, a dead cycle
    // follows every accepted bit except the last.
    task automatic shift_bits(input logic [CFG_WIDTH-1:0] word, input int nbits,
                              input bit throttle, input int base_count);
        for (int i = 0; i < nbits; i++) begin
            bit_in    = word[CFG_WIDTH-1-i];
            bit_valid = 1'b1;
            tick();
            check("bit_count_step", 64'(bit_count), 64'(base_count + i + 1));
            if (throttle && i != nbits - 1) begin
                bit_valid = 1'b0;
                bit_in    = ~bit_in;
                tick();
                check("bit_count_hold", 64'(bit_count), 64'(base_count + i + 1));
            end
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        int s;
        int r;

        // Reset values
        repeat (3) tick();
        config_rst = 1'b0;
        check("rst_config_out", 64'(config_out), 64'h0);
        check("rst_config_en", 64'(config_en), 64'h0);
        check("rst_bit_ready", 64'(bit_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_loaded", 64'(loaded), 64'h0);
        check("rst_bit_count", 64'(bit_count), 64'h0);

        // Full frame
        start_frame(s);
        push_exp(33'h1_DEAD_BEEF, s + 34);
        check("start_bit_ready", 64'(bit_ready), 64'h1);
        check("start_busy", 64'(busy), 64'h1);
        shift_bits(33'h1_DEAD_BEEF, CFG_WIDTH, 1'b0, 0);
        check("commit_bit_ready", 64'(bit_ready), 64'h0);
        check("commit_loaded_low", 64'(loaded), 64'h0);
        tick();
        check("full_loaded", 64'(loaded), 64'h1);
        check("full_idle_busy", 64'(busy), 64'h0);
        check("full_config_en_low", 64'(config_en), 64'h0);
        check("full_split_bit", 64'(config_out[CFG_WIDTH-1]), 64'h1);

        // Throttled frame
        start_frame(s);
        push_exp(33'h0_1234_5678, s + 66);
        check("restart_clears_loaded", 64'(loaded), 64'h0);
        shift_bits(33'h0_1234_5678, CFG_WIDTH, 1'b1, 0);
        tick();
        check("thr_config_out", 64'(config_out), 64'h0_1234_5678);
        check("thr_split_bit", 64'(config_out[CFG_WIDTH-1]), 64'h0);

        // Restart after 10 bits
        start_frame(s);
        shift_bits(33'h1_FFFF_0000, 10, 1'b0, 0);
        load_start = 1'b1;
        bit_valid  = 1'b1;
        bit_in     = 1'b1;
        r          = cyc;
        push_exp(33'h0_0000_FFFF, r + 34);
        tick();
        load_start = 1'b0;
        bit_valid  = 1'b0;
        check("restart_bit_count", 64'(bit_count), 64'h0);
        check("restart_busy", 64'(busy), 64'h1);
        check("restart_config_out_held", 64'(config_out), 64'h0_1234_5678);
        shift_bits(33'h0_0000_FFFF, CFG_WIDTH, 1'b0, 0);
        tick();
        check("restart_final_out", 64'(config_out), 64'h0_0000_FFFF);

        // Stray bit_valid in IDLE, then load_start during COMMIT
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (20) tick();
        bit_valid = 1'b0;
        check("stray_bit_count", 64'(bit_count), 64'(CFG_WIDTH));
        check("stray_busy", 64'(busy), 64'h0);
        check("stray_bit_ready", 64'(bit_ready), 64'h0);
        check("stray_config_out", 64'(config_out), 64'h0_0000_FFFF);
        start_frame(s);
        push_exp(33'h1_A5A5_3C3C, s + 34);
        shift_bits(33'h1_A5A5_3C3C, CFG_WIDTH, 1'b0, 0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("commit_ignores_start_busy", 64'(busy), 64'h0);
        check("commit_ignores_start_ready", 64'(bit_ready), 64'h0);
        check("commit_ignores_start_loaded", 64'(loaded), 64'h1);
        tick();
        check("post_commit_idle", 64'(busy), 64'h0);

        // Reset mid-frame
        start_frame(s);
        shift_bits(33'h1_DEAD_BEEF, 20, 1'b0, 0);
        config_rst = 1'b1;
        bit_valid  = 1'b1;
        tick();
        config_rst = 1'b0;
        bit_valid  = 1'b0;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_config_out", 64'(config_out), 64'h0);
        check("midrst_bit_count", 64'(bit_count), 64'h0);
        check("midrst_loaded", 64'(loaded), 64'h0);
        repeat (40) tick();
        check("midrst_stays_idle", 64'(bit_ready), 64'h0);
        start_frame(s);
        push_exp(33'h0_C0DE_F00D, s + 34);
        shift_bits(33'h0_C0DE_F00D, CFG_WIDTH, 1'b0, 0);
        tick();
        check("midrst_recover_out", 64'(config_out), 64'h0_C0DE_F00D);
        check("midrst_recover_loaded", 64'(loaded), 64'h1);

        // Every pushed commit must have been observed by now.
        repeat (3) tick();
        check("pending_commits", 64'(q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
